// File: rtl/alu_pkg.sv
// alu_pkg
// Shared types for the multicycle ALU: opcode encodings, controller states
// and the opcode-class helper used by the top level to pick the issue path.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_NOR  = 4'b0100,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_MULU = 4'b1000,
    OP_DIVU = 4'b1001
  } aluOp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } aluState_t;

  // Iterator mode select.
  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  // True for opcodes that normally run through the shift/add iterator.
  // DIVU by zero is short-circuited by the top level and does not iterate.
  function automatic logic isIterative(input aluOp_t op);
    return (op == OP_MULU) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter
// One-bit-per-cycle unsigned multiplier (shift-add, LSB first) and
// restoring divider sharing a single {hi, lo} shift register pair.
//
// Ports
//   clk, reset   clock, async active-high reset (drops any operation)
//   start        load operands and begin; counter loads 0
//   mode         MODE_MUL or MODE_DIV, sampled on start
//   a, b         operands, sampled on start
//   done         high during the cycle whose edge performs the last step
//   hi, lo       step result: MUL {high, low} product, DIV {remainder,
//                quotient}; final when done is high
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic             done,
  output logic [width-1:0] hi,
  output logic [width-1:0] lo
);

  // Sized to hold 0..width so it can never wrap before termination.
  localparam int CW = $clog2(width + 1);
  localparam logic [CW-1:0] LAST = CW'(width - 1);

  logic             busy_q;
  logic             mode_q;
  logic [CW-1:0]    cnt_q;
  logic [width-1:0] m_q;    // multiplicand (MUL) or divisor (DIV)
  logic [width-1:0] hi_q;
  logic [width-1:0] lo_q;   // multiplier (MUL) or dividend/quotient (DIV)

  logic [width:0]   sum;
  logic [width:0]   shifted;
  logic [width:0]   diff;
  logic [width-1:0] hi_nxt;
  logic [width-1:0] lo_nxt;

  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    shifted = {hi_q, lo_q[width-1]};
    diff    = shifted - {1'b0, m_q};
    hi_nxt  = hi_q;
    lo_nxt  = lo_q;
    if (mode_q == MODE_MUL) begin
      // Add carry drops into the top of hi; product bits shift into lo.
      hi_nxt = sum[width:1];
      lo_nxt = {sum[0], lo_q[width-1:1]};
    end else begin
      // A clear top bit of diff means the trial subtraction did not borrow.
      if (!diff[width]) begin
        hi_nxt = diff[width-1:0];
        lo_nxt = {lo_q[width-2:0], 1'b1};
      end else begin
        hi_nxt = shifted[width-1:0];
        lo_nxt = {lo_q[width-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      mode_q <= MODE_MUL;
      cnt_q  <= '0;
      m_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      mode_q <= mode;
      cnt_q  <= '0;
      m_q    <= (mode == MODE_DIV) ? b : a;
      hi_q   <= '0;
      lo_q   <= (mode == MODE_DIV) ? a : b;
    end else if (busy_q) begin
      hi_q  <= hi_nxt;
      lo_q  <= lo_nxt;
      cnt_q <= cnt_q + CW'(1);
      if (cnt_q == LAST) busy_q <= 1'b0;
    end
  end

  // The caller captures hi/lo on the same edge as the final step, so the
  // outputs are the step values rather than the registered ones.
  assign done = busy_q && (cnt_q == LAST);
  assign hi   = hi_nxt;
  assign lo   = lo_nxt;

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle
// Sequential ALU between register-read and writeback. Simple ops complete
// on the accept edge; MULU and DIVU (B != 0) iterate one bit per cycle.
//
// state | meaning
// IDLE  | ready for an operation (startReady = 1)
// BUSY  | iterator running MULU/DIVU
// DONE  | result and flags presented until resultReady
//
// Ports
//   clk, reset                clock, async active-high reset
//   startValid / startReady   operand-side handshake
//   inputA, inputB            operands
//   aluControl                opcode (aluOp_t)
//   resultValid / resultReady result-side handshake
//   aluResult, resultHi       result; MUL {hi, lo}, DIV {remainder, quotient}
//   zero, overflow, divByZero registered flags, 0 outside DONE
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startValid,
  output logic             startReady,
  input  logic [width-1:0] inputA,
  input  logic [width-1:0] inputB,
  input  logic [3:0]       aluControl,
  output logic             resultValid,
  input  logic             resultReady,
  output logic [width-1:0] aluResult,
  output logic [width-1:0] resultHi,
  output logic             zero,
  output logic             overflow,
  output logic             divByZero
);

  localparam int MSB = width - 1;

  aluState_t state_q, state_d;
  aluOp_t    op_in;
  logic      accept;
  logic      b_zero;
  logic      iter_go;

  logic             md_done;
  logic [width-1:0] md_hi;
  logic [width-1:0] md_lo;

  logic [width-1:0] add_sum;
  logic [width-1:0] sub_sum;
  logic [width-1:0] b_inv;
  logic             add_ovf;
  logic             sub_ovf;
  logic [width-1:0] s_res;
  logic [width-1:0] s_hi;
  logic             s_ovf;
  logic             s_dbz;

  assign op_in       = aluOp_t'(aluControl);
  assign startReady  = (state_q == IDLE);
  assign resultValid = (state_q == DONE);
  assign accept      = startValid && startReady;
  assign b_zero      = (inputB == '0);
  // Divide by zero has a fixed answer, so it takes the single-cycle path.
  assign iter_go     = isIterative(op_in) && !((op_in == OP_DIVU) && b_zero);

  // Operands for the iterative path are captured inside the iterator on
  // the accept edge; simple results are captured straight into the output
  // registers on that same edge, so later input changes have no effect.
  alu_muldiv_iter #(
    .width(width)
  ) u_iter (
    .clk   (clk),
    .reset (reset),
    .start (accept && iter_go),
    .mode  ((op_in == OP_DIVU) ? MODE_DIV : MODE_MUL),
    .a     (inputA),
    .b     (inputB),
    .done  (md_done),
    .hi    (md_hi),
    .lo    (md_lo)
  );

  // Single-cycle datapath on the live inputs.
  always_comb begin
    add_sum = inputA + inputB;
    add_ovf = (inputA[MSB] == inputB[MSB]) && (add_sum[MSB] != inputA[MSB]);
    b_inv   = ~inputB;
    sub_sum = inputA + b_inv + width'(1);
    sub_ovf = (inputA[MSB] == b_inv[MSB]) && (sub_sum[MSB] != inputA[MSB]);

    s_res = '0;
    s_hi  = '0;
    s_ovf = 1'b0;
    s_dbz = 1'b0;
    case (op_in)
      OP_AND: s_res = inputA & inputB;
      OP_OR:  s_res = inputA | inputB;
      OP_XOR: s_res = inputA ^ inputB;
      OP_NOR: s_res = ~(inputA | inputB);
      OP_ADD: begin
        s_res = add_sum;
        s_ovf = add_ovf;
      end
      OP_SUB: begin
        s_res = sub_sum;
        s_ovf = sub_ovf;
      end
      // Sign of A-B corrected by overflow gives the true signed compare.
      OP_SLT: s_res = {{(width-1){1'b0}}, sub_sum[MSB] ^ sub_ovf};
      OP_DIVU: begin
        if (b_zero) begin
          s_res = '1;
          s_hi  = inputA;
          s_dbz = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = iter_go ? BUSY : DONE;
      BUSY: if (md_done) state_d = DONE;
      DONE: if (resultReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output registers: loaded on entry to DONE, cleared on leaving it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aluResult <= '0;
      resultHi  <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      divByZero <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept && !iter_go) begin
            aluResult <= s_res;
            resultHi  <= s_hi;
            zero      <= (s_res == '0);
            overflow  <= s_ovf;
            divByZero <= s_dbz;
          end
        end
        BUSY: begin
          if (md_done) begin
            aluResult <= md_lo;
            resultHi  <= md_hi;
            zero      <= (md_lo == '0);
            overflow  <= 1'b0;
            divByZero <= 1'b0;
          end
        end
        DONE: begin
          if (resultReady) begin
            aluResult <= '0;
            resultHi  <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            divByZero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         startValid;
  logic         startReady;
  logic [W-1:0] inputA;
  logic [W-1:0] inputB;
  logic [3:0]   aluControl;
  logic         resultValid;
  logic         resultReady;
  logic [W-1:0] aluResult;
  logic [W-1:0] resultHi;
  logic         zero;
  logic         overflow;
  logic         divByZero;

  always #5 clk = ~clk;

  alu_multicycle #(.width(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .startValid  (startValid),
    .startReady  (startReady),
    .inputA      (inputA),
    .inputB      (inputB),
    .aluControl  (aluControl),
    .resultValid (resultValid),
    .resultReady (resultReady),
    .aluResult   (aluResult),
    .resultHi    (resultHi),
    .zero        (zero),
    .overflow    (overflow),
    .divByZero   (divByZero)
  );

  typedef struct packed {
    logic [W-1:0] r;
    logic [W-1:0] hi;
    logic         z;
    logic         o;
    logic         d;
    logic [7:0]   lat;
  } res_t;

  res_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: wide integer arithmetic, latency counted in edges
  // from the accept edge (inclusive) to resultValid.
  function automatic res_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t m;
    logic [2*W-1:0] p;
    longint sa, sb, ss, lim;
    m   = '0;
    m.lat = 8'd1;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lim = longint'(1) << (W - 1);
    case (op)
      4'b0000: m.r = a & b;
      4'b0001: m.r = a | b;
      4'b0011: m.r = a ^ b;
      4'b0100: m.r = ~(a | b);
      4'b0010: begin
        m.r = a + b;
        ss  = sa + sb;
        m.o = (ss >= lim) || (ss < -lim);
      end
      4'b0110: begin
        m.r = a - b;
        ss  = sa - sb;
        m.o = (ss >= lim) || (ss < -lim);
      end
      4'b0111: m.r = (sa < sb) ? W'(1) : W'(0);
      4'b1000: begin
        p     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        m.r   = p[W-1:0];
        m.hi  = p[2*W-1:W];
        m.lat = 8'(W + 1);
      end
      4'b1001: begin
        if (b == '0) begin
          m.r  = '1;
          m.hi = a;
          m.d  = 1'b1;
        end else begin
          m.r   = a / b;
          m.hi  = a % b;
          m.lat = 8'(W + 1);
        end
      end
      default: m.r = '0;
    endcase
    m.z = (m.r == '0);
    return m;
  endfunction

  // Issue one op and wait (bounded) for resultValid. Inputs are scrambled
  // right after the accept edge. rdy_leak flags startReady seen while waiting.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output res_t obs, output bit rdy_leak);
    int n;
    rdy_leak = 1'b0;
    n = 0;
    while (!startReady && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    @(negedge clk);
    inputA = a; inputB = b; aluControl = op; startValid = 1'b1;
    @(posedge clk); #1;
    startValid = 1'b0;
    inputA = $urandom; inputB = $urandom; aluControl = 4'($urandom);
    n = 1;
    while (!resultValid && n < 100) begin
      if (startReady) rdy_leak = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    obs.r   = aluResult;
    obs.hi  = resultHi;
    obs.z   = zero;
    obs.o   = overflow;
    obs.d   = divByZero;
    obs.lat = 8'(n);
  endtask

  task automatic release_result();
    resultReady = 1'b1;
    @(posedge clk); #1;
    resultReady = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; startValid = 1'b0; resultReady = 1'b0;
    inputA = '0; inputB = '0; aluControl = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({startReady, resultValid, aluResult, resultHi, zero, overflow, divByZero} !==
        {1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 3'b000}) begin
      n_bad++;
      $display("FAIL reset_state got rdy=%b vld=%b r=%h hi=%h flags=%b%b%b want rdy=1 vld=0 all zero",
               startReady, resultValid, aluResult, resultHi, zero, overflow, divByZero);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_arith();
    logic [3:0]   ops [8] = '{4'h2, 4'h2, 4'h6, 4'h2, 4'h7, 4'h7, 4'h7, 4'h6};
    logic [W-1:0] as  [8] = '{32'h0, 32'h1, 32'h0, 32'h7FFFFFFF, 32'd5, 32'd7, 32'hFFFFFFFF, 32'h80000000};
    logic [W-1:0] bs  [8] = '{32'h1, 32'hFFFFFFFF, 32'h1, 32'h1, 32'd7, 32'd3, 32'h1, 32'h1};
    res_t obs, e;
    bit   leak;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(model(ops[i], as[i], bs[i]));
      run_op(ops[i], as[i], bs[i], obs, leak);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL arith[%0d] op=%h got r=%h hi=%h z%b o%b d%b lat=%0d want r=%h hi=%h z%b o%b d%b lat=%0d",
                 i, ops[i], obs.r, obs.hi, obs.z, obs.o, obs.d, obs.lat, e.r, e.hi, e.z, e.o, e.d, e.lat);
      end
      release_result();
    end
  endtask

  task automatic test_logic();
    logic [3:0] ops [6] = '{4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'hF};
    res_t obs, e;
    bit   leak;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(model(ops[i], 32'hAAAAAAAA, 32'h55555555));
      run_op(ops[i], 32'hAAAAAAAA, 32'h55555555, obs, leak);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL logic[%0d] op=%h got r=%h hi=%h z%b o%b d%b lat=%0d want r=%h hi=%h z%b o%b d%b lat=%0d",
                 i, ops[i], obs.r, obs.hi, obs.z, obs.o, obs.d, obs.lat, e.r, e.hi, e.z, e.o, e.d, e.lat);
      end
      release_result();
    end
  endtask

  task automatic test_mulu();
    logic [W-1:0] as [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h12345678};
    logic [W-1:0] bs [4] = '{32'h2, 32'hFFFFFFFF, 32'h12345, 32'h9ABCDEF0};
    res_t obs, e;
    bit   leak;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(model(4'h8, as[i], bs[i]));
      run_op(4'h8, as[i], bs[i], obs, leak);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL mulu[%0d] got r=%h hi=%h z%b lat=%0d want r=%h hi=%h z%b lat=%0d",
                 i, obs.r, obs.hi, obs.z, obs.lat, e.r, e.hi, e.z, e.lat);
      end
      n_cmp++;
      if ({leak, startReady} !== 2'b00) begin
        n_bad++;
        $display("FAIL mulu_ready[%0d] got busy_leak=%b done_ready=%b want 0 0", i, leak, startReady);
      end
      release_result();
    end
  endtask

  task automatic test_divu();
    logic [W-1:0] as [5] = '{32'd100, 32'd9, 32'd5, 32'hFFFFFFFF, 32'd0};
    logic [W-1:0] bs [5] = '{32'd7, 32'd0, 32'd9, 32'd1, 32'd0};
    res_t obs, e;
    bit   leak;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(model(4'h9, as[i], bs[i]));
      run_op(4'h9, as[i], bs[i], obs, leak);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL divu[%0d] got q=%h r=%h z%b d%b lat=%0d want q=%h r=%h z%b d%b lat=%0d",
                 i, obs.r, obs.hi, obs.z, obs.d, obs.lat, e.r, e.hi, e.z, e.d, e.lat);
      end
      release_result();
    end
  endtask

  task automatic test_hold();
    res_t obs, e;
    bit   leak;
    exp_q.push_back(model(4'h9, 32'd1000, 32'd33));
    run_op(4'h9, 32'd1000, 32'd33, obs, leak);
    e = exp_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if ({resultValid, aluResult, resultHi, zero, overflow, divByZero} !== {1'b1, e.r, e.hi, e.z, e.o, e.d}) begin
        n_bad++;
        $display("FAIL hold[%0d] got vld=%b r=%h hi=%h z%b o%b d%b want vld=1 r=%h hi=%h z%b o%b d%b",
                 c, resultValid, aluResult, resultHi, zero, overflow, divByZero, e.r, e.hi, e.z, e.o, e.d);
      end
      @(posedge clk); #1;
    end
    release_result();
    n_cmp++;
    if ({startReady, resultValid, aluResult, resultHi, zero, overflow, divByZero} !==
        {1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 3'b000}) begin
      n_bad++;
      $display("FAIL after_release got rdy=%b vld=%b r=%h hi=%h flags=%b%b%b want rdy=1 vld=0 all zero",
               startReady, resultValid, aluResult, resultHi, zero, overflow, divByZero);
    end
  endtask

  task automatic test_reset_midop();
    res_t obs, e;
    bit   leak;
    bit   seen;
    @(negedge clk);
    inputA = 32'hFFFFFFFF; inputB = 32'hFFFFFFFF; aluControl = 4'h8; startValid = 1'b1;
    @(posedge clk); #1;
    startValid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({startReady, resultValid, aluResult, resultHi, zero, overflow, divByZero} !==
        {1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 3'b000}) begin
      n_bad++;
      $display("FAIL midop_reset got rdy=%b vld=%b r=%h hi=%h flags=%b%b%b want rdy=1 vld=0 all zero",
               startReady, resultValid, aluResult, resultHi, zero, overflow, divByZero);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (resultValid) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL midop_ghost got resultValid_seen=%b want 0", seen);
    end
    exp_q.push_back(model(4'h2, 32'd2, 32'd3));
    run_op(4'h2, 32'd2, 32'd3, obs, leak);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL post_reset_add got r=%h z%b o%b lat=%0d want r=%h z%b o%b lat=%0d",
               obs.r, obs.z, obs.o, obs.lat, e.r, e.z, e.o, e.lat);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    logic [3:0]   oplist [9] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h8, 4'h9};
    logic [3:0]   op;
    logic [W-1:0] a, b;
    res_t obs, e;
    bit   leak;
    resultReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      op = oplist[$urandom_range(8)];
      a  = $urandom;
      b  = ($urandom_range(2) == 0) ? W'($urandom_range(20)) : W'($urandom);
      exp_q.push_back(model(op, a, b));
      run_op(op, a, b, obs, leak);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL b2b[%0d] op=%h a=%h b=%h got r=%h hi=%h z%b o%b d%b lat=%0d want r=%h hi=%h z%b o%b d%b lat=%0d",
                 i, op, a, b, obs.r, obs.hi, obs.z, obs.o, obs.d, obs.lat, e.r, e.hi, e.z, e.o, e.d, e.lat);
      end
    end
    @(posedge clk); #1;
    resultReady = 1'b0;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_mulu();
    test_divu();
    test_hold();
    test_reset_midop();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no completion want finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
